// File: rtl/multi_zone_irrigation_ctrl_if.sv
// Sensor/command inputs and valve/display outputs of the multi-zone irrigation
// sequencer, bundled so the front end and the controller share one bus.
interface multi_zone_irrigation_ctrl_if #(
   parameter int NUM_ZONES = 4,
   parameter int TIMER_W   = 8
);
   localparam int ZW = $clog2(NUM_ZONES);

   logic                 start_i;
   logic                 stop_i;
   logic [NUM_ZONES-1:0] soil_dry_i;
   logic [NUM_ZONES-1:0] air_dry_i;
   logic [NUM_ZONES-1:0] hot_i;
   logic                 pesticide_i;
   logic [NUM_ZONES-1:0] valve_o;
   logic [1:0]           mode_o;
   logic [ZW-1:0]        zone_o;
   logic [TIMER_W-1:0]   seconds_left_o;
   logic                 busy_o;
   logic                 alert_on_o;
   logic                 alert_np_o;

   // Front end / sensor side: drives commands and flags, observes the controller.
   modport master (
      output start_i, stop_i, soil_dry_i, air_dry_i, hot_i, pesticide_i,
      input  valve_o, mode_o, zone_o, seconds_left_o, busy_o, alert_on_o, alert_np_o
   );

   // Controller side.
   modport slave (
      input  start_i, stop_i, soil_dry_i, air_dry_i, hot_i, pesticide_i,
      output valve_o, mode_o, zone_o, seconds_left_o, busy_o, alert_on_o, alert_np_o
   );
endinterface

// File: rtl/multi_zone_irrigation_ctrl.sv
// N-zone irrigation sequencer. A round-robin scan picks the next dry zone,
// waters it (sprinkler when hot or dry air, drip otherwise), then runs a
// line-clean phase before resuming the scan after the served zone.
// All outputs are registered from the next-state values, so they line up
// with the state register.
module multi_zone_irrigation_ctrl #(
   parameter int NUM_ZONES      = 4,
   parameter int TIMER_W        = 8,
   parameter int TICK_DIV       = 50000000,
   parameter int SPRINKLER_TIME = 30,
   parameter int DRIP_TIME      = 60,
   parameter int CLEAN_TIME     = 10
) (
   input logic                          clk_50mhz,
   input logic                          reset_n,
   multi_zone_irrigation_ctrl_if.slave  bus
);
   localparam int ZW = $clog2(NUM_ZONES);
   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = $clog2(NUM_ZONES + 1);

   localparam logic [1:0] MODE_NONE  = 2'b00;
   localparam logic [1:0] MODE_DRIP  = 2'b01;
   localparam logic [1:0] MODE_SPRK  = 2'b10;
   localparam logic [1:0] MODE_CLEAN = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SCAN     = 2'd1,
      ST_IRRIGATE = 2'd2,
      ST_CLEAN    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ZW-1:0]         ptr_q, ptr_d;
   logic [CW-1:0]         pass_q, pass_d;
   logic [ZW-1:0]         zone_q, zone_d;
   logic                  sprk_q, sprk_d;
   logic [TIMER_W-1:0]    timer_q, timer_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic                  alert_np_q, alert_np_d;
   logic [NUM_ZONES-1:0]  valve_q, valve_d;
   logic [1:0]            mode_q, mode_d;
   logic [TIMER_W-1:0]    seconds_q, seconds_d;
   logic                  busy_q, busy_d;
   logic                  alert_on_q, alert_on_d;

   logic                  tick;
   logic [ZW-1:0]         ptr_inc;
   logic [ZW-1:0]         zone_inc;
   logic [CW-1:0]         pass_inc;
   logic [NUM_ZONES-1:0]  valve_dec;

   assign tick     = (presc_q == PW'(TICK_DIV - 1));
   assign ptr_inc  = (ptr_q  == ZW'(NUM_ZONES - 1)) ? '0 : ptr_q  + ZW'(1);
   assign zone_inc = (zone_q == ZW'(NUM_ZONES - 1)) ? '0 : zone_q + ZW'(1);
   assign pass_inc = pass_q + CW'(1);

   // One-hot decode of the zone that will be open next cycle.
   for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_valve
      assign valve_dec[gi] = (zone_d == ZW'(gi));
   end

   // Next-state logic: stop has absolute priority, then the per-state sequencing.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      pass_d     = pass_q;
      zone_d     = zone_q;
      sprk_d     = sprk_q;
      timer_d    = timer_q;
      presc_d    = presc_q;
      alert_np_d = alert_np_q;

      if (bus.stop_i) begin
         state_d    = ST_IDLE;
         timer_d    = '0;
         presc_d    = '0;
         alert_np_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               presc_d = '0;
               if (bus.start_i) begin
                  state_d = ST_SCAN;
                  pass_d  = '0;
               end
            end
            ST_SCAN: begin
               presc_d = '0;
               if (bus.soil_dry_i[ptr_q] && bus.pesticide_i) begin
                  state_d    = ST_IRRIGATE;
                  alert_np_d = 1'b0;
                  zone_d     = ptr_q;
                  sprk_d     = bus.hot_i[ptr_q] | bus.air_dry_i[ptr_q];
                  timer_d    = (bus.hot_i[ptr_q] | bus.air_dry_i[ptr_q])
                               ? TIMER_W'(SPRINKLER_TIME) : TIMER_W'(DRIP_TIME);
               end else begin
                  // Zone skipped: either wet, or dry but refused for lack of pesticide.
                  if (bus.soil_dry_i[ptr_q]) begin
                     alert_np_d = 1'b1;
                  end
                  ptr_d  = ptr_inc;
                  pass_d = pass_inc;
                  if (pass_inc == CW'(NUM_ZONES)) begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_IRRIGATE: begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick) begin
                  if ((timer_q == TIMER_W'(1)) || !bus.soil_dry_i[zone_q]) begin
                     state_d = ST_CLEAN;
                     timer_d = TIMER_W'(CLEAN_TIME);
                     presc_d = '0;
                  end else begin
                     timer_d = timer_q - TIMER_W'(1);
                  end
               end
            end
            ST_CLEAN: begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick) begin
                  if (timer_q == TIMER_W'(1)) begin
                     // Resume after the served zone so every other dry zone gets a turn first.
                     state_d = ST_SCAN;
                     ptr_d   = zone_inc;
                     pass_d  = '0;
                     presc_d = '0;
                  end else begin
                     timer_d = timer_q - TIMER_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next-state values so outputs register together with the state.
   always_comb begin
      valve_d   = '0;
      mode_d    = MODE_NONE;
      seconds_d = '0;
      if (state_d == ST_IRRIGATE) begin
         valve_d   = valve_dec;
         mode_d    = sprk_d ? MODE_SPRK : MODE_DRIP;
         seconds_d = timer_d;
      end else if (state_d == ST_CLEAN) begin
         mode_d    = MODE_CLEAN;
         seconds_d = timer_d;
      end
      busy_d     = (state_d != ST_IDLE);
      alert_on_d = |valve_d;
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         pass_q     <= '0;
         zone_q     <= '0;
         sprk_q     <= 1'b0;
         timer_q    <= '0;
         presc_q    <= '0;
         alert_np_q <= 1'b0;
         valve_q    <= '0;
         mode_q     <= MODE_NONE;
         seconds_q  <= '0;
         busy_q     <= 1'b0;
         alert_on_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         pass_q     <= pass_d;
         zone_q     <= zone_d;
         sprk_q     <= sprk_d;
         timer_q    <= timer_d;
         presc_q    <= presc_d;
         alert_np_q <= alert_np_d;
         valve_q    <= valve_d;
         mode_q     <= mode_d;
         seconds_q  <= seconds_d;
         busy_q     <= busy_d;
         alert_on_q <= alert_on_d;
      end
   end

   assign bus.valve_o        = valve_q;
   assign bus.mode_o         = mode_q;
   assign bus.zone_o         = zone_q;
   assign bus.seconds_left_o = seconds_q;
   assign bus.busy_o         = busy_q;
   assign bus.alert_on_o     = alert_on_q;
   assign bus.alert_np_o     = alert_np_q;
endmodule

// File: tb/tb_multi_zone_irrigation_ctrl.sv
// Directed bench for the multi-zone irrigation sequencer with a short tick.
module tb_multi_zone_irrigation_ctrl;
   localparam int NZ = 4;
   localparam int TW = 8;

   logic clk;
   logic reset_n;
   int   total  = 0;
   int   passed = 0;
   int   failed = 0;

   multi_zone_irrigation_ctrl_if #(.NUM_ZONES(NZ), .TIMER_W(TW)) bus ();

   multi_zone_irrigation_ctrl #(
      .NUM_ZONES(NZ), .TIMER_W(TW), .TICK_DIV(4),
      .SPRINKLER_TIME(3), .DRIP_TIME(5), .CLEAN_TIME(2)
   ) dut (
      .clk_50mhz (clk),
      .reset_n   (reset_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] valve, input logic [1:0] mode,
                          input logic [1:0] zone, input logic [7:0] sec, input logic busy);
      chk({tag, ".valve"},    32'(bus.valve_o),        32'(valve));
      chk({tag, ".mode"},     32'(bus.mode_o),         32'(mode));
      chk({tag, ".zone"},     32'(bus.zone_o),         32'(zone));
      chk({tag, ".seconds"},  32'(bus.seconds_left_o), 32'(sec));
      chk({tag, ".busy"},     32'(bus.busy_o),         32'(busy));
      chk({tag, ".alert_on"}, 32'(bus.alert_on_o),     32'(valve != 4'b0000));
      $display("step %s: valve=%b mode=%b zone=%0d sec=%0d busy=%b alert_np=%b",
               tag, bus.valve_o, bus.mode_o, bus.zone_o, bus.seconds_left_o, bus.busy_o,
               bus.alert_np_o);
   endtask

   task automatic do_reset();
      bus.start_i = 1'b0;
      bus.stop_i  = 1'b0;
      reset_n     = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(1);
   endtask

   task automatic pulse_start();
      bus.start_i = 1'b1;
      step(1);
      bus.start_i = 1'b0;
   endtask

   initial begin
      reset_n         = 1'b0;
      bus.start_i     = 1'b0;
      bus.stop_i      = 1'b0;
      bus.soil_dry_i  = '0;
      bus.air_dry_i   = '0;
      bus.hot_i       = '0;
      bus.pesticide_i = 1'b1;
      step(2);
      chk_out("reset", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b0);
      chk("reset.alert_np", 32'(bus.alert_np_o), 32'd0);
      reset_n = 1'b1;
      step(1);
      chk_out("idle", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b0);

      // Single hot zone 2: sprinkler 3 s, clean 2 s, then wet scan back to idle.
      do_reset();
      bus.soil_dry_i = 4'b0100; bus.hot_i = 4'b0100; bus.air_dry_i = 4'b0000;
      pulse_start();
      chk_out("t2.scan0", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b1);
      step(2);
      chk_out("t2.scan2", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b1);
      step(1);
      chk_out("t2.irr_k0", 4'b0100, 2'b10, 2'd2, 8'd3, 1'b1);
      step(3);
      chk_out("t2.irr_k3", 4'b0100, 2'b10, 2'd2, 8'd3, 1'b1);
      step(1);
      chk_out("t2.irr_k4", 4'b0100, 2'b10, 2'd2, 8'd2, 1'b1);
      step(4);
      chk_out("t2.irr_k8", 4'b0100, 2'b10, 2'd2, 8'd1, 1'b1);
      step(3);
      chk_out("t2.irr_k11", 4'b0100, 2'b10, 2'd2, 8'd1, 1'b1);
      step(1);
      chk_out("t2.cln_k12", 4'b0000, 2'b11, 2'd2, 8'd2, 1'b1);
      bus.soil_dry_i = 4'b0000; bus.hot_i = 4'b0000;
      step(7);
      chk_out("t2.cln_k19", 4'b0000, 2'b11, 2'd2, 8'd1, 1'b1);
      step(1);
      chk_out("t2.scan_k20", 4'b0000, 2'b00, 2'd2, 8'd0, 1'b1);
      step(3);
      chk_out("t2.scan_k23", 4'b0000, 2'b00, 2'd2, 8'd0, 1'b1);
      step(1);
      chk_out("t2.idle_k24", 4'b0000, 2'b00, 2'd2, 8'd0, 1'b0);

      // Zones 0 and 3 stay dry: they alternate, drip 20 cycles, clean 8 cycles.
      do_reset();
      bus.soil_dry_i = 4'b1001;
      pulse_start();
      step(1);
      chk_out("t3.z0a_k0", 4'b0001, 2'b01, 2'd0, 8'd5, 1'b1);
      step(19);
      chk_out("t3.z0a_k19", 4'b0001, 2'b01, 2'd0, 8'd1, 1'b1);
      step(1);
      chk_out("t3.cln_k20", 4'b0000, 2'b11, 2'd0, 8'd2, 1'b1);
      step(7);
      chk_out("t3.cln_k27", 4'b0000, 2'b11, 2'd0, 8'd1, 1'b1);
      step(1);
      chk_out("t3.scan_k28", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b1);
      step(3);
      chk_out("t3.z3a_k31", 4'b1000, 2'b01, 2'd3, 8'd5, 1'b1);
      step(20);
      chk_out("t3.cln_k51", 4'b0000, 2'b11, 2'd3, 8'd2, 1'b1);
      step(8);
      chk_out("t3.scan_k59", 4'b0000, 2'b00, 2'd3, 8'd0, 1'b1);
      step(1);
      chk_out("t3.z0b_k60", 4'b0001, 2'b01, 2'd0, 8'd5, 1'b1);
      step(31);
      chk_out("t3.z3b_k91", 4'b1000, 2'b01, 2'd3, 8'd5, 1'b1);
      bus.stop_i = 1'b1;
      step(1);
      bus.stop_i = 1'b0;
      chk_out("t3.stop", 4'b0000, 2'b00, 2'd3, 8'd0, 1'b0);

      // No pesticide: refused grant raises the sticky alert, then a refill grants zone 1.
      do_reset();
      bus.soil_dry_i = 4'b0010; bus.pesticide_i = 1'b0;
      pulse_start();
      chk("t4.np_scan0", 32'(bus.alert_np_o), 32'd0);
      step(2);
      chk_out("t4.refused", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b1);
      chk("t4.np_set", 32'(bus.alert_np_o), 32'd1);
      step(2);
      chk_out("t4.idle", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b0);
      chk("t4.np_sticky", 32'(bus.alert_np_o), 32'd1);
      bus.pesticide_i = 1'b1;
      pulse_start();
      chk("t4.np_restart", 32'(bus.alert_np_o), 32'd1);
      step(2);
      chk_out("t4.grant_z1", 4'b0010, 2'b01, 2'd1, 8'd5, 1'b1);
      chk("t4.np_clear", 32'(bus.alert_np_o), 32'd0);

      // Stop during zone 2 drip, with a simultaneous start that must be ignored.
      do_reset();
      bus.soil_dry_i = 4'b0100;
      pulse_start();
      step(3);
      chk_out("t5.irr_k0", 4'b0100, 2'b01, 2'd2, 8'd5, 1'b1);
      step(5);
      chk_out("t5.irr_k5", 4'b0100, 2'b01, 2'd2, 8'd4, 1'b1);
      bus.stop_i = 1'b1; bus.start_i = 1'b1;
      step(1);
      bus.stop_i = 1'b0; bus.start_i = 1'b0;
      chk_out("t5.stopped", 4'b0000, 2'b00, 2'd2, 8'd0, 1'b0);
      step(3);
      chk_out("t5.stay_idle", 4'b0000, 2'b00, 2'd2, 8'd0, 1'b0);

      // Early finish: soil goes wet at cycle 5 of a drip, clean starts at cycle 8.
      do_reset();
      bus.soil_dry_i = 4'b0001;
      pulse_start();
      step(1);
      chk_out("t6.irr_k0", 4'b0001, 2'b01, 2'd0, 8'd5, 1'b1);
      step(5);
      chk_out("t6.irr_k5", 4'b0001, 2'b01, 2'd0, 8'd4, 1'b1);
      bus.soil_dry_i = 4'b0000;
      step(2);
      chk_out("t6.irr_k7", 4'b0001, 2'b01, 2'd0, 8'd4, 1'b1);
      step(1);
      chk_out("t6.cln_k8", 4'b0000, 2'b11, 2'd0, 8'd2, 1'b1);
      step(7);
      chk_out("t6.cln_k15", 4'b0000, 2'b11, 2'd0, 8'd1, 1'b1);
      step(1);
      chk_out("t6.scan_k16", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b1);
      step(3);
      chk_out("t6.scan_k19", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b1);
      step(1);
      chk_out("t6.idle_k20", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b0);

      // Air-dry zone 0 selects sprinkler; reset mid-irrigation clears outputs without an edge.
      do_reset();
      bus.soil_dry_i = 4'b0001; bus.air_dry_i = 4'b0001;
      pulse_start();
      step(1);
      chk_out("t1.irr_k0", 4'b0001, 2'b10, 2'd0, 8'd3, 1'b1);
      step(2);
      #2;
      reset_n = 1'b0;
      #1;
      chk_out("t1.async_rst", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b0);
      reset_n = 1'b1;
      step(1);
      chk_out("t1.after_rst", 4'b0000, 2'b00, 2'd0, 8'd0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
